// File: rtl/wash_sequencer.sv
// Purpose: washing-machine program sequencer (wash / rinse / spin) with pause, cancel and display codes.
// Latency: stage and count changes appear one clk after the causing pulse or tick; IDLE yTot follows uMode combinationally.
// Backpressure: none; uStart/uCancel are single-cycle pulses acted on immediately, uCancel taking priority.
module wash_sequencer #(
  parameter int SEC_CYCLES = 100000000,
  parameter int T_WASH     = 20,
  parameter int T_RINSE    = 15,
  parameter int T_SPIN     = 10,
  parameter int WAT_LVL    = 30
) (
  input  logic       clk,
  input  logic       uRst_,
  input  logic       uStart,
  input  logic       uCancel,
  input  logic [1:0] uMode,
  output logic [5:0] yTot,
  output logic [5:0] yCur,
  output logic [5:0] yWat,
  output logic [2:0] yMotor,
  output logic       yBuzz
);

  // State encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WASH  = 3'd1;
  localparam logic [2:0] S_RINSE = 3'd2;
  localparam logic [2:0] S_SPIN  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Display codes shown instead of a number
  localparam logic [5:0] D_BLANK = 6'd55;
  localparam logic [5:0] D_PAUSE = 6'd57;
  localparam logic [5:0] D_DONE  = 6'd58;

  // Stage lengths and program totals in seconds
  localparam logic [5:0] LEN_WASH  = 6'(T_WASH);
  localparam logic [5:0] LEN_RINSE = 6'(T_RINSE);
  localparam logic [5:0] LEN_SPIN  = 6'(T_SPIN);
  localparam logic [5:0] WAT_VAL   = 6'(WAT_LVL);
  localparam logic [5:0] TOT_ALL   = 6'(T_WASH + T_RINSE + T_SPIN);
  localparam logic [5:0] TOT_RS    = 6'(T_RINSE + T_SPIN);

  // One-second prescaler sizing
  localparam int             PW        = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(SEC_CYCLES - 1);

  // Program total for a mode
  function automatic logic [5:0] progTotal(input logic [1:0] m);
    case (m)
      2'd0:    return TOT_ALL;
      2'd1:    return LEN_WASH;
      2'd2:    return TOT_RS;
      default: return LEN_SPIN;
    endcase
  endfunction

  // First running stage of a mode
  function automatic logic [2:0] firstStage(input logic [1:0] m);
    case (m)
      2'd0, 2'd1: return S_WASH;
      2'd2:       return S_RINSE;
      default:    return S_SPIN;
    endcase
  endfunction

  // Stage following the given one; only mode 0 continues past wash,
  // and every program containing rinse continues into spin.
  function automatic logic [2:0] nextStage(input logic [1:0] m, input logic [2:0] st);
    case (st)
      S_WASH:  return (m == 2'd0) ? S_RINSE : S_DONE;
      S_RINSE: return S_SPIN;
      default: return S_DONE;
    endcase
  endfunction

  // Length of a running stage
  function automatic logic [5:0] stageLen(input logic [2:0] st);
    case (st)
      S_WASH:  return LEN_WASH;
      S_RINSE: return LEN_RINSE;
      default: return LEN_SPIN;
    endcase
  endfunction

  logic [2:0]    state, stateNxt;
  logic [2:0]    pState, pStateNxt;   // stage to resume from PAUSE
  logic [1:0]    modeQ, modeNxt;      // program latched at start
  logic [PW-1:0] presc, prescNxt;
  logic [5:0]    totCnt, totNxt;
  logic [5:0]    curCnt, curNxt;      // kept intact while PAUSE displays its marker
  logic [5:0]    yTotQ, yTotNxt;
  logic [5:0]    yCurNxt, yWatNxt;
  logic [2:0]    yMotorNxt;
  logic          yBuzzNxt;
  logic          running, tick;

  assign running = (state == S_WASH) || (state == S_RINSE) || (state == S_SPIN);
  assign tick    = running && (presc == PRESC_MAX);

  // Next state, prescaler and counters
  always_comb begin
    stateNxt  = state;
    pStateNxt = pState;
    modeNxt   = modeQ;
    prescNxt  = presc;
    totNxt    = totCnt;
    curNxt    = curCnt;
    case (state)
      S_IDLE: begin
        if (uStart) begin
          modeNxt  = uMode;
          stateNxt = firstStage(uMode);
          curNxt   = stageLen(firstStage(uMode));
          totNxt   = progTotal(uMode);
          prescNxt = '0;
        end
      end
      S_WASH, S_RINSE, S_SPIN: begin
        prescNxt = tick ? '0 : presc + PW'(1);
        if (tick) begin
          totNxt = totCnt - 6'd1;
          if (curCnt == 6'd1) begin
            stateNxt = nextStage(modeQ, state);
            if (stateNxt != S_DONE) begin
              curNxt = stageLen(stateNxt);
            end
          end else begin
            curNxt = curCnt - 6'd1;
          end
        end
        // A pause landing on a tick remembers the stage the tick produced;
        // a pause coinciding with the final tick is superseded by DONE.
        if (uStart && (stateNxt != S_DONE)) begin
          pStateNxt = stateNxt;
          stateNxt  = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (uStart) begin
          stateNxt = pState;
        end
      end
      S_DONE: begin
        if (uStart) begin
          stateNxt = S_IDLE;
        end
      end
      default: stateNxt = S_IDLE;
    endcase
    if (uCancel && (state != S_IDLE)) begin
      stateNxt  = S_IDLE;
      pStateNxt = S_IDLE;
      prescNxt  = '0;
      totNxt    = '0;
      curNxt    = '0;
    end
  end

  // Registered display values derived from the upcoming state
  always_comb begin
    yCurNxt   = curNxt;
    yTotNxt   = totNxt;
    yWatNxt   = 6'd0;
    yMotorNxt = 3'b000;
    yBuzzNxt  = 1'b0;
    case (stateNxt)
      S_IDLE: yCurNxt = D_BLANK;
      S_WASH: begin
        yWatNxt   = WAT_VAL;
        yMotorNxt = 3'b001;
      end
      S_RINSE: begin
        yWatNxt   = WAT_VAL;
        yMotorNxt = 3'b010;
      end
      S_SPIN: yMotorNxt = 3'b100;
      S_PAUSE: begin
        yCurNxt = D_PAUSE;
        yWatNxt = yWat;
      end
      S_DONE: begin
        yCurNxt  = D_DONE;
        yTotNxt  = D_DONE;
        yBuzzNxt = 1'b1;
      end
      default: yCurNxt = D_BLANK;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge uRst_) begin
    if (!uRst_) begin
      state  <= S_IDLE;
      pState <= S_IDLE;
      modeQ  <= 2'd0;
      presc  <= '0;
      totCnt <= 6'd0;
      curCnt <= 6'd0;
      yTotQ  <= TOT_ALL;
      yCur   <= D_BLANK;
      yWat   <= 6'd0;
      yMotor <= 3'b000;
      yBuzz  <= 1'b0;
    end else begin
      state  <= stateNxt;
      pState <= pStateNxt;
      modeQ  <= modeNxt;
      presc  <= prescNxt;
      totCnt <= totNxt;
      curCnt <= curNxt;
      yTotQ  <= yTotNxt;
      yCur   <= yCurNxt;
      yWat   <= yWatNxt;
      yMotor <= yMotorNxt;
      yBuzz  <= yBuzzNxt;
    end
  end

  // IDLE previews the selected program total; reset forces the mode-0 total
  assign yTot = (state == S_IDLE) ? (uRst_ ? progTotal(uMode) : TOT_ALL) : yTotQ;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed program scenarios plus random pulses,
// every cycle compared against a model based on elapsed running time.
module tb_wash_sequencer;

  localparam int SEC = 4;
  localparam int TW  = 20;
  localparam int TR  = 15;
  localparam int TS  = 10;
  localparam int WL  = 30;

  logic       clk = 1'b0;
  logic       uRst_;
  logic       uStart;
  logic       uCancel;
  logic [1:0] uMode;
  logic [5:0] yTot;
  logic [5:0] yCur;
  logic [5:0] yWat;
  logic [2:0] yMotor;
  logic       yBuzz;

  wash_sequencer #(
    .SEC_CYCLES(SEC), .T_WASH(TW), .T_RINSE(TR), .T_SPIN(TS), .WAT_LVL(WL)
  ) dut (
    .clk(clk), .uRst_(uRst_), .uStart(uStart), .uCancel(uCancel), .uMode(uMode),
    .yTot(yTot), .yCur(yCur), .yWat(yWat), .yMotor(yMotor), .yBuzz(yBuzz)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Model: 0 idle, 1 running, 2 paused, 3 done; progress is the count of running clk edges
  int         mst;
  int         runCyc;
  int         pWat;
  logic [1:0] mMode;

  initial begin
    if (TW < 1 || TR < 1 || TS < 1 || TW + TR + TS > 54) begin
      $display("FAIL params: stage times out of range");
      $fatal(1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, want %0d @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit inProg(input logic [1:0] m, input int i);
    case (m)
      2'd0:    return 1'b1;
      2'd1:    return i == 0;
      2'd2:    return i >= 1;
      default: return i == 2;
    endcase
  endfunction

  function automatic int stLen(input int i);
    return (i == 0) ? TW : (i == 1) ? TR : TS;
  endfunction

  function automatic int progTot(input logic [1:0] m);
    int s = 0;
    for (int i = 0; i < 3; i++) if (inProg(m, i)) s += stLen(i);
    return s;
  endfunction

  task automatic modelReset();
    mst = 0; runCyc = 0; pWat = 0; mMode = 2'd0;
  endtask

  task automatic expOut(output int t, output int c, output int w, output int m, output int b);
    int el, s, cur, acc;
    el = runCyc / SEC; s = 0; cur = 0; acc = 0;
    for (int i = 0; i < 3; i++) begin
      if (inProg(mMode, i)) begin
        acc += stLen(i);
        if (cur == 0 && el < acc) begin
          s = i;
          cur = acc - el;
        end
      end
    end
    case (mst)
      0: begin t = uRst_ ? progTot(uMode) : progTot(2'd0); c = 55; w = 0; m = 0; b = 0; end
      1: begin t = progTot(mMode) - el; c = cur; w = (s < 2) ? WL : 0; m = 1 << s; b = 0; end
      2: begin t = progTot(mMode) - el; c = 57; w = pWat; m = 0; b = 0; end
      default: begin t = 58; c = 58; w = 0; m = 0; b = 1; end
    endcase
  endtask

  task automatic modelEdge(input logic st, input logic ca, input logic [1:0] md);
    int t, c, w, m, b;
    expOut(t, c, w, m, b);
    case (mst)
      0: if (st) begin mMode = md; runCyc = 0; mst = 1; end
      1: begin
        if (ca) mst = 0;
        else begin
          runCyc++;
          if (runCyc / SEC >= progTot(mMode)) mst = 3;
          else if (st) begin mst = 2; pWat = w; end
        end
      end
      2: if (ca) mst = 0; else if (st) mst = 1;
      default: if (ca || st) mst = 0;
    endcase
  endtask

  task automatic checkAll();
    int t, c, w, m, b;
    expOut(t, c, w, m, b);
    chk("yTot", 32'(yTot), t);
    chk("yCur", 32'(yCur), c);
    chk("yWat", 32'(yWat), w);
    chk("yMotor", 32'(yMotor), m);
    chk("yBuzz", 32'(yBuzz), b);
  endtask

  task automatic step(input logic st, input logic ca, input logic [1:0] md);
    @(negedge clk);
    uStart = st; uCancel = ca; uMode = md;
    @(posedge clk);
    modelEdge(st, ca, md);
    #1;
    checkAll();
    uStart = 1'b0; uCancel = 1'b0;
  endtask

  task automatic waitSteps(input int n);
    repeat (n) step(1'b0, 1'b0, uMode);
  endtask

  task automatic asyncReset();
    @(negedge clk);
    #2 uRst_ = 1'b0;
    #1 modelReset();
    checkAll();
    @(negedge clk);
    uRst_ = 1'b1;
  endtask

  initial begin
    uRst_ = 1'b0; uStart = 1'b0; uCancel = 1'b0; uMode = 2'd0;
    modelReset();
    #12;
    chk("rst_yTot", 32'(yTot), 45);
    chk("rst_yCur", 32'(yCur), 55);
    chk("rst_yWat", 32'(yWat), 0);
    chk("rst_yMotor", 32'(yMotor), 0);
    chk("rst_yBuzz", 32'(yBuzz), 0);
    uMode = 2'd2;
    #1 chk("rst_yTot_mode2", 32'(yTot), 45);
    @(negedge clk);
    uRst_ = 1'b1; uMode = 2'd0;

    // Full program, mode 0
    step(1'b1, 1'b0, 2'd0);
    chk("full_start_tot", 32'(yTot), 45);
    chk("full_start_cur", 32'(yCur), 20);
    chk("full_start_motor", 32'(yMotor), 1);
    chk("full_start_wat", 32'(yWat), 30);
    waitSteps(20 * SEC);
    chk("full_rinse_tot", 32'(yTot), 25);
    chk("full_rinse_cur", 32'(yCur), 15);
    chk("full_rinse_motor", 32'(yMotor), 2);
    waitSteps(15 * SEC);
    chk("full_spin_tot", 32'(yTot), 10);
    chk("full_spin_cur", 32'(yCur), 10);
    chk("full_spin_motor", 32'(yMotor), 4);
    chk("full_spin_wat", 32'(yWat), 0);
    waitSteps(10 * SEC);
    chk("full_done_tot", 32'(yTot), 58);
    chk("full_done_cur", 32'(yCur), 58);
    chk("full_done_buzz", 32'(yBuzz), 1);
    step(1'b1, 1'b0, 2'd0);
    chk("full_ack_cur", 32'(yCur), 55);

    // Spin-only program
    step(1'b1, 1'b0, 2'd3);
    chk("spin_start_tot", 32'(yTot), 10);
    chk("spin_start_cur", 32'(yCur), 10);
    chk("spin_start_motor", 32'(yMotor), 4);
    waitSteps(10 * SEC);
    chk("spin_done_buzz", 32'(yBuzz), 1);
    step(1'b1, 1'b0, 2'd3);
    chk("spin_idle_cur", 32'(yCur), 55);
    chk("spin_idle_tot", 32'(yTot), 10);

    // Pause and resume, wash only
    step(1'b1, 1'b0, 2'd1);
    step(1'b0, 1'b0, 2'd1);
    step(1'b1, 1'b0, 2'd1);
    chk("pause_cur", 32'(yCur), 57);
    chk("pause_motor", 32'(yMotor), 0);
    waitSteps(100);
    chk("pause_hold_cur", 32'(yCur), 57);
    chk("pause_hold_tot", 32'(yTot), 20);
    step(1'b1, 1'b0, 2'd1);
    chk("resume_cur", 32'(yCur), 20);
    chk("resume_motor", 32'(yMotor), 1);
    waitSteps(2);
    chk("resume_tick_cur", 32'(yCur), 19);
    step(1'b0, 1'b1, 2'd1);

    // Pause landing on the wash-to-rinse tick
    step(1'b1, 1'b0, 2'd0);
    waitSteps(20 * SEC - 1);
    chk("bnd_pre_cur", 32'(yCur), 1);
    step(1'b1, 1'b0, 2'd0);
    chk("bnd_pause_cur", 32'(yCur), 57);
    chk("bnd_pause_tot", 32'(yTot), 25);
    chk("bnd_pause_wat", 32'(yWat), 30);
    step(1'b1, 1'b0, 2'd0);
    chk("bnd_resume_motor", 32'(yMotor), 2);
    chk("bnd_resume_cur", 32'(yCur), 15);
    waitSteps(5);

    // Cancel together with start during rinse
    step(1'b1, 1'b1, 2'd0);
    chk("cancel_motor", 32'(yMotor), 0);
    chk("cancel_cur", 32'(yCur), 55);
    chk("cancel_tot", 32'(yTot), 45);

    // Asynchronous reset mid-spin
    step(1'b1, 1'b0, 2'd0);
    waitSteps(37 * SEC + 2);
    chk("arst_pre_motor", 32'(yMotor), 4);
    @(negedge clk);
    #2 uRst_ = 1'b0;
    #1;
    chk("arst_yTot", 32'(yTot), 45);
    chk("arst_yCur", 32'(yCur), 55);
    chk("arst_yWat", 32'(yWat), 0);
    chk("arst_yMotor", 32'(yMotor), 0);
    chk("arst_yBuzz", 32'(yBuzz), 0);
    modelReset();
    @(negedge clk);
    uRst_ = 1'b1;

    // Random pulses, modes and occasional resets
    for (int i = 0; i < 8000; i++) begin
      logic       st, ca;
      logic [1:0] md;
      st = ($urandom_range(0, 24) == 0);
      ca = ($urandom_range(0, 199) == 0);
      md = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : uMode;
      if ($urandom_range(0, 2999) == 0) asyncReset();
      else step(st, ca, md);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
